// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the write-controller state type.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register file geometry
//   REG_ZERO                           : hard-wired $zero address
//   state_e                            : write-controller state (clear / run)
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/mips_reg_write_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : index of the requester that currently has top priority
//   grant     : one-hot grant of the first requester at or after ptr (or 0)
//   grant_idx : index of the granted requester (0 when nothing is granted)
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic        found;
    int unsigned idx;

    // Walk the requesters starting at ptr, wrapping modulo N; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mips_reg_write_ctrl.sv
// Write-port controller for the MIPS register file.
// After Reset it writes zero to registers 1..NUM_REGS-1 (one per cycle), then
// shares the single write port between NUM_REQ writeback sources with
// round-robin arbitration and a valid/ready handshake.
//   Clk, Reset  : clock (rising edge), synchronous active-high reset
//   req_valid   : per-requester write request
//   req_addr    : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data    : packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready   : one-hot combinational grant (all 0 during the clear)
//   RegWrite    : registered register-file write enable
//   WriteAddr   : registered register-file write address
//   WriteData   : registered register-file write data
//   init_done   : registered, high once the clear has completed
module mips_reg_write_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W   = mips_pkg::REG_DATA_W,
    parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          WriteAddr,
    output logic [DATA_W-1:0]          WriteData,
    output logic                       init_done
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                init_done_q, init_done_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                fire;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_q == ST_RUN) ? grant : '0;
    assign fire      = |(req_valid & req_ready);
    assign sel_addr  = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[32'(grant_idx)*DATA_W +: DATA_W];

    // State register and all datapath flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= ADDR_W'(1);
            rr_ptr_q     <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            rr_ptr_q     <= rr_ptr_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            init_done_q  <= init_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        clr_addr_d   = clr_addr_q;
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        init_done_d  = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                reg_write_d  = 1'b1;
                write_addr_d = clr_addr_q;
                write_data_d = '0;
                clr_addr_d   = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) init_done_d = 1'b1;
            end
            ST_RUN: begin
                if (fire) begin
                    // A $zero write is consumed but never enabled.
                    reg_write_d  = (sel_addr != ADDR_W'(REG_ZERO));
                    write_addr_d = sel_addr;
                    write_data_d = sel_data;
                    rr_ptr_d     = PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
                end
            end
            default: ;
        endcase
    end

    assign RegWrite  = reg_write_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;
    assign init_done = init_done_q;

endmodule

// File: doc/mips_reg_write_ctrl.md
Name: mips_reg_write_ctrl

Overview:
- Write-port controller for the 32x32 MIPS register file; sole driver of its RegWrite/WriteAddr/WriteData.
- After reset, it zeroes registers 1..31 through the normal write port, one per cycle; the register file's own combinational Reset is then unused.
- After the clear, it shares the single write port between NUM_REQ writeback sources (e.g. ALU result and load data) with round-robin arbitration and a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, register count; clear walks 1..NUM_REGS-1.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high; restarts the clear sequence.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  output  NUM_REQ  one-hot grant (or all 0); combinational.
- RegWrite  output  1  register file write enable; registered.
- WriteAddr  output  ADDR_W  register file write address; registered.
- WriteData  output  DATA_W  register file write data; registered.
- init_done  output  1  high once the clear sequence has completed; registered.

Behaviour:
- Reset (sampled high at a rising edge):
  - state=CLEAR, clr_addr=1, rr_ptr=0.
  - RegWrite=0, WriteAddr=0, WriteData=0, init_done=0.
  - Reset overrides everything, including mid-clear or mid-transfer; no in-flight write survives.
- State CLEAR:
  - req_ready is all 0.
  - Each edge: RegWrite<=1, WriteAddr<=clr_addr, WriteData<=0, clr_addr++.
  - Edge with clr_addr==NUM_REGS-1: state<=RUN, init_done<=1.
  - Result: 31 consecutive write pulses, addresses 1..31. init_done rises together with the address-31 write.
  - Address 0 is never written.
- State RUN, arbitration (combinational, same cycle):
  - Search requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - A transfer occurs when req_valid[i] & req_ready[i] at the edge.
  - On a transfer by requester i: rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- State RUN, write issue (latency 1 cycle):
  - Transfer with req_addr!=0: RegWrite<=1, WriteAddr<=req_addr, WriteData<=req_data.
  - Transfer with req_addr==0: the request is accepted and consumed, but RegWrite<=0 (the $zero write is dropped). WriteAddr/WriteData still load.
  - No transfer: RegWrite<=0; WriteAddr/WriteData hold their previous values.
- Throughput: one accepted write per cycle. A requester holding valid continuously is served at least once every NUM_REQ cycles.
- Requesters keep addr/data stable while valid and not ready. The controller does not check this.
- init_done stays 1 until the next Reset.
- No read-side control: read ports stay direct from the datapath. Same-cycle read/write forwarding is the register file's concern.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0.
  - State encoding constants ST_CLEAR=1'b0, ST_RUN=1'b1.
- One natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs req[N], ptr[$clog2(N)].
  - Outputs grant[N] (one-hot or 0), grant_idx.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset clear: hold Reset 2 cycles, release -> RegWrite=1 for exactly 31 cycles, WriteAddr 1,2,...,31, WriteData=0; init_done=1 on the cycle WriteAddr=31; req_ready=0 throughout CLEAR.
- Single write: after init, req_valid=01, req_addr[0]=5'd8, req_data[0]=32'hDEADBEEF -> req_ready=01 the same cycle; next cycle RegWrite=1, WriteAddr=8, WriteData=32'hDEADBEEF; following cycle RegWrite=0.
- Round-robin contention: both valid continuously (req0 addr 3 data 32'h11, req1 addr 4 data 32'h22), rr_ptr=0 -> grants alternate 01,10,01,10; WriteAddr sequence 3,4,3,4 with no idle cycles.
- $zero drop: req_valid=10, req_addr[1]=0, req_data[1]=32'hFFFFFFFF -> req_ready=10, next cycle RegWrite=0; then req1 addr 9 -> written normally, and rr_ptr advanced (req0 now has priority).
- Reset mid-clear: assert Reset when WriteAddr=12 -> next cycle RegWrite=0, init_done=0; after release the clear restarts at address 1 and runs all 31 writes.
- Reset mid-traffic: in RUN with both valid, assert Reset for 1 cycle -> no write issued for the accepted-pending slot, req_ready=0, full clear repeats, rr_ptr=0 (req0 served first afterwards).
